// File: rtl/ahb_slave_if_if.sv
// Signal bundle between the AHB master and the slave front-end,
// plus the simple req/ack backend bus driven by the slave.
interface ahb_slave_if_if;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        be_req;
  logic        be_write;
  logic [31:0] be_addr;
  logic [31:0] be_wdata;
  logic [2:0]  be_sel;
  logic        be_ack;
  logic [31:0] be_rdata;

  modport slave (
    input  hwrite, hreadyin, htrans,
    input  haddr, hwdata,
    input  be_ack, be_rdata,
    output hreadyout, hresp, hrdata,
    output be_req, be_write, be_addr,
    output be_wdata, be_sel
  );

  modport master (
    output hwrite, hreadyin, htrans,
    output haddr, hwdata,
    output be_ack, be_rdata,
    input  hreadyout, hresp, hrdata,
    input  be_req, be_write, be_addr,
    input  be_wdata, be_sel
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front-end: decodes three regions, turns each
// accepted transfer into one backend req/ack, errors unmapped ones.
// Ports: hclk, hreset (sync, active-high), bus (slave modport:
//   AHB hwrite/hreadyin/htrans/haddr/hwdata -> hreadyout/hresp/hrdata,
//   backend be_req/be_write/be_addr/be_wdata/be_sel <- be_ack/be_rdata).
// Optional: WAIT_TIMEOUT_EN aborts a REQ with ERROR after
//   TIMEOUT_CYCLES cycles without be_ack.
module ahb_slave_if #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          hclk,
  input  logic          hreset,
  ahb_slave_if_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DP,
    S_REQ,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [2:0]  sel;
  logic        rdy;
  logic        active;
  logic        valid;
  logic        accept;
  logic [1:0]  hresp_c;
  logic [31:0] hrdata_q;
  logic        req_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  sel_q;
  logic        unused_htrans0;

`ifdef WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          tmo;
  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  assign unused_htrans0 = bus.htrans[0];

  always_comb begin
    sel = 3'b000;
    unique case (bus.haddr[31:26])
      6'b100000: sel = 3'b001;
      6'b100001: sel = 3'b010;
      6'b100010: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
  end

  // Ready depends on state only, so it can gate "active" safely.
  assign rdy = (state == S_IDLE) ||
               (state == S_DONE) ||
               (state == S_ERR2);

  assign active = bus.hreadyin & rdy & bus.htrans[1];
  assign valid  = active & (sel != 3'b000);
  // ERR2 is ready but drops any transfer sampled there.
  assign accept = valid &
                  ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    nxt     = state;
    hresp_c = 2'b00;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (valid)       nxt = S_DP;
        else if (active) nxt = S_ERR1;
        else             nxt = S_IDLE;
      end
      S_DP: nxt = S_REQ;
      S_REQ: begin
        if (bus.be_ack) nxt = S_DONE;
`ifdef WAIT_TIMEOUT_EN
        else if (tmo)   nxt = S_ERR1;
`endif
      end
      S_ERR1: begin
        hresp_c = 2'b01;
        nxt     = S_ERR2;
      end
      S_ERR2: begin
        hresp_c = 2'b01;
        nxt     = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= S_IDLE;
      hrdata_q <= '0;
      req_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
    end else begin
      state <= nxt;
      req_q <= (nxt == S_REQ);
      if (accept) begin
        addr_q  <= bus.haddr;
        write_q <= bus.hwrite;
        sel_q   <= sel;
      end
      if (state == S_DP && write_q)
        wdata_q <= bus.hwdata;
      if (state == S_REQ && bus.be_ack && !write_q)
        hrdata_q <= bus.be_rdata;
    end
  end

`ifdef WAIT_TIMEOUT_EN
  always_ff @(posedge hclk) begin
    if (hreset)
      tcnt <= '0;
    else if (state == S_DP)
      tcnt <= '0;
    else if (state == S_REQ && !bus.be_ack)
      tcnt <= tcnt + TW'(1);
  end
`endif

  assign bus.hreadyout = rdy;
  assign bus.hresp     = hresp_c;
  assign bus.hrdata    = hrdata_q;
  assign bus.be_req    = req_q;
  assign bus.be_write  = write_q;
  assign bus.be_addr   = addr_q;
  assign bus.be_wdata  = wdata_q;
  assign bus.be_sel    = sel_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if with a backend scoreboard.
// Build with -DWAIT_TIMEOUT_EN to also exercise the timeout path.
module tb_ahb_slave_if;

  logic hclk = 1'b0;
  logic hreset = 1'b1;

  ahb_slave_if_if bus ();

  ahb_slave_if dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } be_t;

  be_t         sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  int          waits;
  int          n;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_be();
    be_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: got be_req want none");
    end else begin
      e = sb.pop_front();
      chk("be_write", 32'(bus.be_write), 32'(e.w));
      chk("be_addr", bus.be_addr, e.a);
      chk("be_wdata", bus.be_wdata, e.d);
      chk("be_sel", 32'(bus.be_sel), 32'(e.s));
    end
  endtask

  task automatic addr_phase(input logic wr,
                            input logic [31:0] addr,
                            input logic [31:0] wdata,
                            input logic [2:0] sel);
    be_t e;
    e.w = wr;
    e.a = addr;
    e.s = sel;
    if (wr) m_wdata = wdata;
    e.d = m_wdata;
    sb.push_back(e);
    bus.htrans = 2'b10;
    bus.hwrite = wr;
    bus.haddr  = addr;
    tick();
    bus.htrans = 2'b00;
    bus.hwdata = wdata;
  endtask

  // Runs wait states until hreadyout returns; acks on REQ cycle nreq.
  task automatic data_phase(input int nreq,
                            input logic [31:0] rdata,
                            output int w);
    int reqc;
    bit seen;
    reqc = 0;
    seen = 0;
    w = 0;
    for (int k = 0; k < 64 && bus.hreadyout === 1'b0; k++) begin
      if (bus.be_req === 1'b1) begin
        reqc++;
        if (!seen) check_be();
        seen = 1;
      end
      bus.be_ack   = (reqc == nreq) && (bus.be_req === 1'b1);
      bus.be_rdata = rdata;
      w++;
      tick();
      bus.be_ack = 1'b0;
    end
    if (bus.hreadyout !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL dp_bound: got no ready want ready");
    end
  endtask

  initial begin
    bus.hwrite   = 1'b0;
    bus.hreadyin = 1'b1;
    bus.htrans   = 2'b00;
    bus.haddr    = '0;
    bus.hwdata   = '0;
    bus.be_ack   = 1'b0;
    bus.be_rdata = '0;
    hreset       = 1'b1;
    tick();
    tick();
    hreset = 1'b0;

    chk("rst_hready", 32'(bus.hreadyout), 32'd1);
    chk("rst_hresp", 32'(bus.hresp), 32'd0);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_be_req", 32'(bus.be_req), 32'd0);
    chk("rst_be_write", 32'(bus.be_write), 32'd0);
    chk("rst_be_addr", bus.be_addr, 32'd0);
    chk("rst_be_wdata", bus.be_wdata, 32'd0);
    chk("rst_be_sel", 32'(bus.be_sel), 32'd0);

    // Single write, immediate ack.
    addr_phase(1'b1, 32'h8100_0000, 32'd30, 3'b001);
    data_phase(1, 32'h0, waits);
    chk("wr_waits", 32'(waits), 32'd2);
    chk("wr_hresp", 32'(bus.hresp), 32'd0);
    chk("wr_hrdata", bus.hrdata, m_rdata);
    chk("wr_be_req", 32'(bus.be_req), 32'd0);
    tick();

    // Single read, ack on third REQ cycle.
    addr_phase(1'b0, 32'h8400_0010, 32'h0, 3'b010);
    data_phase(3, 32'hDEAD_BEEF, waits);
    m_rdata = 32'hDEAD_BEEF;
    chk("rd_waits", 32'(waits), 32'd4);
    chk("rd_hresp", 32'(bus.hresp), 32'd0);
    chk("rd_hrdata", bus.hrdata, m_rdata);
    tick();

    // Unmapped address.
    bus.htrans = 2'b10;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h9000_0000;
    tick();
    bus.htrans = 2'b00;
    chk("e1_hready", 32'(bus.hreadyout), 32'd0);
    chk("e1_hresp", 32'(bus.hresp), 32'd1);
    chk("e1_be_req", 32'(bus.be_req), 32'd0);
    tick();
    chk("e2_hready", 32'(bus.hreadyout), 32'd1);
    chk("e2_hresp", 32'(bus.hresp), 32'd1);
    tick();
    chk("e3_hready", 32'(bus.hreadyout), 32'd1);
    chk("e3_hresp", 32'(bus.hresp), 32'd0);
    chk("e3_be_req", 32'(bus.be_req), 32'd0);

    // Back-to-back writes, second issued in DONE.
    addr_phase(1'b1, 32'h8000_0100, 32'h1111_2222, 3'b001);
    data_phase(2, 32'h0, waits);
    chk("b1_waits", 32'(waits), 32'd3);
    addr_phase(1'b1, 32'h8800_0004, 32'h3333_4444, 3'b100);
    chk("b2_nogap", 32'(bus.hreadyout), 32'd0);
    data_phase(1, 32'h0, waits);
    chk("b2_waits", 32'(waits), 32'd2);
    chk("b2_hresp", 32'(bus.hresp), 32'd0);
    chk("b2_hrdata", bus.hrdata, m_rdata);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    tick();

    // Reset while in REQ; late ack must be ignored.
    bus.htrans = 2'b10;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h8400_0000;
    tick();
    bus.htrans = 2'b00;
    tick();
    chk("mr_be_req_on", 32'(bus.be_req), 32'd1);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    m_rdata = '0;
    m_wdata = '0;
    chk("mr_be_req", 32'(bus.be_req), 32'd0);
    chk("mr_hready", 32'(bus.hreadyout), 32'd1);
    chk("mr_hresp", 32'(bus.hresp), 32'd0);
    chk("mr_be_sel", 32'(bus.be_sel), 32'd0);
    bus.be_ack   = 1'b1;
    bus.be_rdata = 32'hBAD0_BAD0;
    tick();
    bus.be_ack = 1'b0;
    tick();
    chk("la_be_req", 32'(bus.be_req), 32'd0);
    chk("la_hready", 32'(bus.hreadyout), 32'd1);
    chk("la_hrdata", bus.hrdata, m_rdata);

`ifdef WAIT_TIMEOUT_EN
    // Read that is never acked.
    addr_phase(1'b0, 32'h8400_0020, 32'h0, 3'b010);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.be_req === 1'b1) begin
        if (n == 0) check_be();
        n++;
      end else if (n > 0) begin
        break;
      end
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd16);
    chk("to_e1_hready", 32'(bus.hreadyout), 32'd0);
    chk("to_e1_hresp", 32'(bus.hresp), 32'd1);
    tick();
    chk("to_e2_hresp", 32'(bus.hresp), 32'd1);
    chk("to_e2_hready", 32'(bus.hreadyout), 32'd1);
    tick();
    chk("to_hresp", 32'(bus.hresp), 32'd0);
    chk("to_hrdata", bus.hrdata, m_rdata);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-Lite slave front-end sitting directly downstream of the team's AHB master.
- Consumes the master's hwrite/hreadyin/htrans/haddr/hwdata and returns hreadyout/hresp/hrdata.
- Decodes three peripheral regions and converts each accepted transfer into a single req/ack transaction on a simple backend bus, inserting AHB wait states until the backend acknowledges.
- Answers unmapped addresses with a two-cycle AHB ERROR response.

Parameters:
- TIMEOUT_CYCLES, 16: maximum REQ cycles without be_ack before an error (used only when WAIT_TIMEOUT_EN is defined).

Ports:
- hclk  input  1  clock; all logic on rising edge
- hreset  input  1  synchronous reset, active-high
- hwrite  input  1  1=write, 0=read (address phase)
- hreadyin  input  1  bus ready from master/mux
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- haddr  input  32  transfer address
- hwdata  input  32  write data (data phase)
- hreadyout  output  1  slave ready; 0 = wait state
- hresp  output  2  00 OKAY, 01 ERROR
- hrdata  output  32  read data
- be_req  output  1  backend request, registered
- be_write  output  1  backend direction
- be_addr  output  32  backend address
- be_wdata  output  32  backend write data
- be_sel  output  3  one-hot region select
- be_ack  input  1  backend acknowledge, single-cycle pulse
- be_rdata  input  32  backend read data, valid with be_ack

Behaviour:
- Reset: hreset sampled high at a posedge forces state IDLE from any state, including mid-transfer. Reset values: hreadyout=1, hresp=00, hrdata=0, be_req=0, be_write=0, be_addr=0, be_wdata=0, be_sel=000, timeout counter=0.
- Active transfer: hreadyin=1 & hreadyout=1 & htrans[1]=1 (NONSEQ or SEQ).
- Decode: 0x8000_0000–0x83FF_FFFF -> sel 001; 0x8400_0000–0x87FF_FFFF -> 010; 0x8800_0000–0x8BFF_FFFF -> 100. Any other address is unmapped.
- valid = active transfer & mapped.
- IDLE and BUSY transfers always receive a zero-wait OKAY; no backend activity.
- States and transitions:
  - IDLE: hreadyout=1, hresp=00. On valid, capture haddr/hwrite/sel into be_addr/be_write/be_sel and go DP. On an active unmapped transfer, go ERR1.
  - DP (data phase): hreadyout=0. Capture hwdata into be_wdata (writes only) and go REQ.
  - REQ: be_req=1, hreadyout=0. On be_ack=1: load be_rdata into hrdata if read (writes leave hrdata unchanged), deassert be_req at that edge, go DONE.
  - DONE: hreadyout=1, hresp=00; the transfer completes this cycle. A pipelined next transfer sampled here is handled exactly as in IDLE (valid -> DP, unmapped -> ERR1); otherwise go IDLE.
  - ERR1: hreadyout=0, hresp=01 -> ERR2.
  - ERR2: hreadyout=1, hresp=01 -> IDLE. Any transfer presented during ERR2 is dropped; the master reissues it.
- Latency: minimum 3 cycles from address-phase sample to completion (DP, one REQ cycle with immediate ack, DONE). Each extra REQ cycle adds one wait state.
- be_ack is ignored outside REQ. An ack held for several cycles acknowledges only one request.
- hwdata must remain stable through DP; only the DP-cycle value is captured.
- be_addr, be_write and be_sel hold their values until the next valid capture.

Optional Feature:
- Macro: WAIT_TIMEOUT_EN.
- Defined: a counter clears on REQ entry and increments each REQ cycle without be_ack. After TIMEOUT_CYCLES cycles, be_req deasserts, hrdata is unchanged, and the state goes to ERR1. be_ack arriving in the same cycle as the timeout wins; the transfer completes OKAY.
- Undefined: no counter; REQ waits indefinitely.

Test Plan:
- Single write: NONSEQ, hwrite=1, haddr=0x8100_0000, hwdata=30; be_ack 1 cycle after be_req -> be_sel=001, be_addr=0x8100_0000, be_wdata=30, be_write=1; hreadyout low 2 cycles; hresp=00.
- Single read: NONSEQ, hwrite=0, haddr=0x8400_0010; be_ack after 3 REQ cycles with be_rdata=0xDEAD_BEEF -> be_sel=010, hrdata=0xDEAD_BEEF on the DONE cycle; 4 wait states.
- Unmapped: NONSEQ to 0x9000_0000 -> no be_req; ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01), then IDLE with hresp=00.
- Back-to-back: second NONSEQ write to 0x8800_0004 presented in the DONE cycle of the first -> accepted without an IDLE gap, be_sel=100, both writes reach the backend in order.
- Reset mid-op: assert hreset during REQ -> next edge be_req=0, hreadyout=1, hresp=00, be_sel=000; a late be_ack is ignored.
- Timeout (WAIT_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with be_ack never asserted -> be_req drops after 16 REQ cycles, ERROR response follows, hrdata unchanged.
